// File: rtl/irs_readout_sequencer.sv
// rtl/irs_readout_sequencer.sv - IRS daughter readout sequencer: select, clear, Wilkinson convert, channel/sample scan
module irs_readout_sequencer #(
    parameter int RD_SETTLE   = 4,
    parameter int CLR_CYCLES  = 4,
    parameter int WILK_CYCLES = 1024,
    parameter int DAT_SETTLE  = 2,
    parameter int NCH         = 8,
    parameter int NSMP        = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic [9:0]  block_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [9:0]  irs_rd_o,
    output logic        irs_rden_o,
    output logic        irs_clr_o,
    output logic        irs_ramp_o,
    output logic        irs_start_o,
    output logic        irs_smpall_o,
    output logic [2:0]  irs_ch_o,
    output logic [5:0]  irs_smp_o,
    input  logic [11:0] irs_dat_i,
    output logic [11:0] dat_o,
    output logic [2:0]  dat_ch_o,
    output logic [5:0]  dat_smp_o,
    output logic        dat_valid_o,
    input  logic        dat_ready_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_CLEAR,
        S_CONVERT,
        S_SETTLE,
        S_VALID,
        S_DONE
    } state_t;

    localparam logic [15:0] RD_LAST   = 16'(RD_SETTLE - 1);
    localparam logic [15:0] CLR_LAST  = 16'(CLR_CYCLES - 1);
    localparam logic [15:0] WILK_LAST = 16'(WILK_CYCLES - 1);
    localparam logic [15:0] DAT_LAST  = 16'(DAT_SETTLE - 1);
    localparam logic [2:0]  CH_LAST   = 3'(NCH - 1);
    localparam logic [5:0]  SMP_LAST  = 6'(NSMP - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  ch_q, ch_d;
    logic [5:0]  smp_q, smp_d;
    logic [9:0]  rd_q, rd_d;
    logic [11:0] dat_q, dat_d;
    logic [2:0]  dat_ch_q, dat_ch_d;
    logic [5:0]  dat_smp_q, dat_smp_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            smp_q     <= '0;
            rd_q      <= '0;
            dat_q     <= '0;
            dat_ch_q  <= '0;
            dat_smp_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            smp_q     <= smp_d;
            rd_q      <= rd_d;
            dat_q     <= dat_d;
            dat_ch_q  <= dat_ch_d;
            dat_smp_q <= dat_smp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        smp_d     = smp_q;
        rd_d      = rd_q;
        dat_d     = dat_q;
        dat_ch_d  = dat_ch_q;
        dat_smp_d = dat_smp_q;

        // cnt_q is shared by every timed phase and restarts at 0 on each transition
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    rd_d    = block_i;
                    cnt_d   = '0;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (cnt_q == RD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_CLEAR: begin
                if (cnt_q == CLR_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CONVERT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_CONVERT: begin
                if (cnt_q == WILK_LAST) begin
                    cnt_d   = '0;
                    ch_d    = '0;
                    smp_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == DAT_LAST) begin
                    cnt_d     = '0;
                    dat_d     = irs_dat_i;
                    dat_ch_d  = ch_q;
                    dat_smp_d = smp_q;
                    state_d   = S_VALID;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_VALID: begin
                if (dat_ready_i) begin
                    if (ch_q == CH_LAST && smp_q == SMP_LAST) begin
                        state_d = S_DONE;
                    end else if (smp_q == SMP_LAST) begin
                        smp_d   = '0;
                        ch_d    = ch_q + 3'd1;
                        state_d = S_SETTLE;
                    end else begin
                        smp_d   = smp_q + 6'd1;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort clears the block address too, so every irs_* pin is quiet afterwards
        if (abort_i && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            ch_d      = '0;
            smp_d     = '0;
            rd_d      = '0;
            dat_d     = '0;
            dat_ch_d  = '0;
            dat_smp_d = '0;
        end
    end

    always_comb begin
        busy_o       = (state_q != S_IDLE);
        done_o       = (state_q == S_DONE);
        irs_rd_o     = rd_q;
        irs_rden_o   = (state_q != S_IDLE) && (state_q != S_DONE);
        irs_clr_o    = (state_q == S_CLEAR);
        irs_ramp_o   = (state_q == S_CONVERT);
        irs_start_o  = (state_q == S_CONVERT);
        irs_smpall_o = (state_q == S_CLEAR) || (state_q == S_CONVERT);
        irs_ch_o     = '0;
        irs_smp_o    = '0;
        if (state_q == S_SETTLE || state_q == S_VALID) begin
            irs_ch_o  = ch_q;
            irs_smp_o = smp_q;
        end
        dat_o       = dat_q;
        dat_ch_o    = dat_ch_q;
        dat_smp_o   = dat_smp_q;
        dat_valid_o = (state_q == S_VALID);
    end

endmodule

// File: tb/tb_irs_readout_sequencer.sv
// tb/tb_irs_readout_sequencer.sv - scoreboard bench for irs_readout_sequencer
module tb_irs_readout_sequencer;

    localparam int WILK = 16;

    logic        clk = 1'b0;
    logic        rst_n, req, abort, ready;
    logic [9:0]  block;
    logic        busy_o, done_o, irs_rden_o, irs_clr_o, irs_ramp_o, irs_start_o, irs_smpall_o;
    logic [9:0]  irs_rd_o;
    logic [2:0]  irs_ch_o, dat_ch_o;
    logic [5:0]  irs_smp_o, dat_smp_o;
    logic [11:0] irs_dat, dat_o;
    logic        dat_valid_o;

    irs_readout_sequencer #(.WILK_CYCLES(WILK)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .block_i(block), .abort_i(abort),
        .busy_o(busy_o), .done_o(done_o), .irs_rd_o(irs_rd_o), .irs_rden_o(irs_rden_o),
        .irs_clr_o(irs_clr_o), .irs_ramp_o(irs_ramp_o), .irs_start_o(irs_start_o),
        .irs_smpall_o(irs_smpall_o), .irs_ch_o(irs_ch_o), .irs_smp_o(irs_smp_o),
        .irs_dat_i(irs_dat), .dat_o(dat_o), .dat_ch_o(dat_ch_o), .dat_smp_o(dat_smp_o),
        .dat_valid_o(dat_valid_o), .dat_ready_i(ready)
    );

    always #5 clk = ~clk;
    assign irs_dat = {irs_ch_o, irs_smp_o, 3'b000};

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [20:0] sb[$];
    int clr_cnt = 0, ramp_cnt = 0, rden_cnt = 0, done_cnt = 0, word_cnt = 0, start_cnt = 0;
    int c_clr, c_ramp, c_rden, c_done, c_word, c_start;
    logic        pv = 0, p_clr = 0, p_ramp = 0, p_done = 0, p_busy = 0;
    logic [20:0] pword = '0;
    logic [9:0]  exp_rd = '0;

    task automatic push_readout();
        for (int c = 0; c < 8; c++)
            for (int s = 0; s < 64; s++)
                sb.push_back({3'(c), 6'(s), 3'(c), 6'(s), 3'b000});
    endtask

    // One cycle: sample at the falling edge, settle the previous word's handshake, update stats.
    task automatic step();
        logic [20:0] e;
        @(negedge clk);
        if (pv && ready && !abort && rst_n) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                e = sb.pop_front();
                chk("word", pword, e);
            end
            word_cnt++;
        end
        pv    = dat_valid_o;
        pword = {dat_ch_o, dat_smp_o, dat_o};
        if (irs_clr_o) clr_cnt++;
        if (irs_ramp_o && irs_start_o) ramp_cnt++;
        if (irs_rden_o) rden_cnt++;
        if (done_o) done_cnt++;
        if (busy_o && !p_busy) start_cnt++;
        if (irs_ramp_o && !p_ramp) chk("ramp_after_clr", p_clr, 1);
        if (p_done) chk("busy_after_done", busy_o, 0);
        if (irs_rden_o) chk("rd_hold", irs_rd_o, exp_rd);
        p_clr  = irs_clr_o;
        p_ramp = irs_ramp_o;
        p_done = done_o;
        p_busy = busy_o;
    endtask

    task automatic snap();
        c_clr = clr_cnt; c_ramp = ramp_cnt; c_rden = rden_cnt;
        c_done = done_cnt; c_word = word_cnt; c_start = start_cnt;
    endtask

    task automatic start_req(input logic [9:0] b);
        block  = b;
        exp_rd = b;
        req    = 1'b1;
        push_readout();
        step();
        req = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        if (done_cnt == d0) chk("done_timeout", 0, 1);
    endtask

    task automatic run_checks(input int n, input int exp_rden);
        chk("clr_cycles", clr_cnt - c_clr, 4 * n);
        chk("ramp_cycles", ramp_cnt - c_ramp, WILK * n);
        chk("rden_cycles", rden_cnt - c_rden, exp_rden);
        chk("word_count", word_cnt - c_word, 512 * n);
        chk("done_pulses", done_cnt - c_done, n);
        chk("starts", start_cnt - c_start, n);
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_strobes"}, {irs_rden_o, irs_clr_o, irs_ramp_o, irs_start_o, irs_smpall_o}, 0);
        chk({tag, "_rd"}, irs_rd_o, 0);
        chk({tag, "_chsmp"}, {irs_ch_o, irs_smp_o}, 0);
        chk({tag, "_valid"}, dat_valid_o, 0);
    endtask

    initial begin
        logic [20:0] w;
        int n;
        rst_n = 1'b0; req = 1'b0; abort = 1'b0; ready = 1'b1; block = '0;
        step(); step();
        chk_quiet("reset");
        chk("reset_dat", {dat_ch_o, dat_smp_o, dat_o}, 0);
        rst_n = 1'b1;
        step();

        // clean readout, ready always high
        snap();
        start_req(10'h2A5);
        wait_done(4000);
        step(); step();
        run_checks(1, 4 + 4 + WILK + 512 * 3);

        // backpressure on word (3,17)
        snap();
        start_req(10'h155);
        n = 0;
        while (!(dat_valid_o && dat_ch_o == 3'd3 && dat_smp_o == 6'd17) && n < 2000) begin
            step();
            n++;
        end
        chk("bp_found", n < 2000, 1);
        w = {dat_ch_o, dat_smp_o, dat_o};
        chk("bp_word", w, {3'd3, 6'd17, 3'd3, 6'd17, 3'b000});
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_stable", {dat_ch_o, dat_smp_o, dat_o}, w);
            chk("bp_valid", dat_valid_o, 1);
        end
        ready = 1'b1;
        wait_done(4000);
        step(); step();
        run_checks(1, 4 + 4 + WILK + 512 * 3 + 5);

        // req held through the readout and the IDLE cycle after done
        snap();
        block  = 10'h0F0;
        exp_rd = 10'h0F0;
        req    = 1'b1;
        push_readout();
        push_readout();
        wait_done(4000);
        step();
        chk("gap_idle", busy_o, 0);
        step();
        chk("second_start", busy_o, 1);
        req = 1'b0;
        wait_done(4000);
        step(); step();
        run_checks(2, 2 * (4 + 4 + WILK + 512 * 3));

        // abort at CONVERT cycle 8
        snap();
        start_req(10'h3FF);
        n = 0;
        while (!irs_ramp_o && n < 100) begin
            step();
            n++;
        end
        chk("convert_found", irs_ramp_o, 1);
        repeat (7) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_quiet("abort");
        repeat (4) step();
        chk("abort_no_done", done_cnt - c_done, 0);
        sb.delete();

        snap();
        start_req(10'h001);
        wait_done(4000);
        step(); step();
        run_checks(1, 4 + 4 + WILK + 512 * 3);

        // asynchronous reset while a word is waiting
        start_req(10'h2A5);
        n = 0;
        while (!(dat_valid_o && dat_ch_o == 3'd1) && n < 2000) begin
            step();
            n++;
        end
        chk("rst_valid_found", dat_valid_o, 1);
        rst_n = 1'b0;
        #1;
        chk_quiet("async_rst");
        chk("async_rst_dat", {dat_ch_o, dat_smp_o, dat_o}, 0);
        step(); step();
        rst_n = 1'b1;
        sb.delete();
        step();
        chk("post_rst_idle", busy_o, 0);

        snap();
        start_req(10'h12A);
        wait_done(4000);
        step(); step();
        run_checks(1, 4 + 4 + WILK + 512 * 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irs_readout_sequencer.md
Name: irs_readout_sequencer

Overview:
- Sequences one IRS daughter digitizer readout: select the analog storage block, clear, Wilkinson-convert, then scan every channel/sample, returning 12-bit words over a valid/ready stream.
- Sits between the event-readout logic and the daughter pins D1RD, D1RDEN, D1CLR, D1RAMP, D1START, D1CH, D1SMP, D1SMPALL and D1DAT.
- Handles one daughter per instance; the multi-daughter top instantiates one per daughter.

Parameters:
- RD_SETTLE, 4, cycles read address and RDEN are held before clear (1..255).
- CLR_CYCLES, 4, cycles CLR is held high (1..255).
- WILK_CYCLES, 1024, cycles RAMP/START are held high for Wilkinson conversion (1..65535).
- DAT_SETTLE, 2, cycles after CH/SMP change before D1DAT is sampled (1..15).
- NCH, 8, channels scanned (1..8).
- NSMP, 64, samples per channel scanned (1..64).

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- req_i  in  1  readout request; sampled only in IDLE.
- block_i  in  10  storage block address; latched on request acceptance.
- abort_i  in  1  abandon readout; returns to IDLE.
- busy_o  out  1  high from acceptance through DONE.
- done_o  out  1  one-cycle pulse at normal completion.
- irs_rd_o  out  10  read block address to D1RD.
- irs_rden_o  out  1  read enable to D1RDEN.
- irs_clr_o  out  1  to D1CLR.
- irs_ramp_o  out  1  to D1RAMP.
- irs_start_o  out  1  to D1START.
- irs_smpall_o  out  1  to D1SMPALL.
- irs_ch_o  out  3  channel select to D1CH.
- irs_smp_o  out  6  sample select to D1SMP.
- irs_dat_i  in  12  converted data from D1DAT.
- dat_o  out  12  captured sample.
- dat_ch_o  out  3  channel of dat_o.
- dat_smp_o  out  6  sample of dat_o.
- dat_valid_o  out  1  dat_o valid.
- dat_ready_i  in  1  consumer accepts dat_o.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Clock and reset: one clock domain (clk_i); rst_n_i is asynchronous, active-low.
- States: IDLE, SELECT, CLEAR, CONVERT, SETTLE, VALID, DONE.
- IDLE:
  - When req_i=1, latch block_i into irs_rd_o.
  - Next cycle: SELECT, busy_o=1, irs_rden_o=1.
- SELECT: exactly RD_SETTLE cycles, then CLEAR.
- CLEAR:
  - irs_clr_o=1 and irs_smpall_o=1 for exactly CLR_CYCLES cycles; then CONVERT.
- CONVERT:
  - irs_clr_o=0; irs_ramp_o=irs_start_o=1; irs_smpall_o=1, all for exactly WILK_CYCLES cycles.
  - Then ramp/start/smpall drop to 0 and the state moves to SETTLE with ch=0, smp=0.
- SETTLE:
  - irs_ch_o/irs_smp_o show the current ch/smp for DAT_SETTLE cycles.
  - On the last cycle, irs_dat_i is registered into dat_o, with dat_ch_o/dat_smp_o set to ch/smp. Next: VALID.
- VALID:
  - dat_valid_o=1; dat_o/dat_ch_o/dat_smp_o stay stable until dat_valid_o & dat_ready_i.
  - On handshake, dat_valid_o=0 next cycle.
  - Scan order is channel-major: smp increments, wrapping at NSMP-1 to 0 with ch+1; otherwise return to SETTLE.
  - After ch=NCH-1, smp=NSMP-1 is handed off, go to DONE.
- DONE (1 cycle): done_o=1; irs_rden_o=0; irs_rd_o is held. Next cycle: IDLE, busy_o=0.
- irs_rden_o is high from SELECT through the last VALID.
- Throughput: with dat_ready_i held high, one word per DAT_SETTLE+1 cycles.
- Request handling:
  - req_i is ignored while busy_o=1; there is no queueing.
  - The request must be re-presented after done_o.
  - A request in the cycle DONE→IDLE is accepted only from IDLE, i.e. at least one cycle after done_o.
- abort_i:
  - In any non-IDLE state, abort_i forces IDLE on the next edge.
  - All irs_* strobes, dat_valid_o and busy_o go to 0; done_o is not pulsed.
  - An in-flight dat_o is dropped.
  - abort_i in IDLE has no effect; abort_i has priority over req_i.
- Counters: the WILK_CYCLES counter is 16 bits; ch is 3 bits; smp is 6 bits. No other arithmetic.
- Asynchronous reset mid-readout: immediate return to reset values, with no glitch on done_o.

Test Plan:
- Defaults except WILK_CYCLES=16 and dat_ready_i=1. Pulse req_i with block_i=10'h2A5.
  - irs_rd_o=2A5 and rden=1 for 4+4+16+512×3 cycles; clr high exactly 4 cycles.
  - ramp/start high exactly 16 cycles, starting the cycle after clr falls.
  - 512 words in order (0,0),(0,1)…(7,63); done_o pulses once; busy_o falls the cycle after.
- irs_dat_i driven as {ch,smp,3'b0}: every dat_o equals {dat_ch_o,dat_smp_o,3'b0}.
- Backpressure: dat_ready_i low for 5 cycles on word (3,17) → dat_o/ch/smp stable with valid held high; no word lost or duplicated; final count 512.
- req_i held high for the entire readout and one cycle past done_o → exactly two readouts, the second starting ≥1 cycle after done_o.
- abort_i asserted during CONVERT (cycle 8 of 16):
  - Next cycle all irs_* outputs, busy_o and dat_valid_o are 0; done_o is never asserted.
  - A following req_i runs a full clean readout.
- rst_n_i low mid-VALID with dat_valid_o=1 → all outputs 0 asynchronously; after release, IDLE; req_i starts a fresh sequence at ch=0, smp=0.
